// File: rtl/mult_share_sequencer.sv
// rtl/mult_share_sequencer.sv - round-robin sequencer for a shared shift-add multiplier datapath
module mult_share_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             dp_lsb,
    output logic [WIDTH-1:0] dp_mcand,
    output logic [WIDTH-1:0] dp_mplier,
    output logic             init,
    output logic             add_en,
    output logic             shift,
    output logic             last_iter,
    output logic             busy,
    output logic             owner,
    output logic [1:0]       done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ITERS   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] counter;
    logic             owner_r;
    logic             last_owner;
    logic             grant_valid;
    logic             grant_idx;

    // Arbitration: a lone request wins outright, a tie goes to whoever was not served last
    always_comb begin
        grant_idx   = 1'b0;
        grant_valid = (state == S_IDLE) && (req != 2'b00);
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_owner;
            default: grant_idx = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant capture and iteration counter; last_owner starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            counter    <= '0;
            owner_r    <= 1'b0;
            last_owner <= 1'b1;
        end else if (grant_valid) begin
            owner_r    <= grant_idx;
            last_owner <= grant_idx;
            counter    <= ITERS;
        end else if (state == S_SHIFT) begin
            counter <= counter - CNT_ONE;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next = state;
        init       = 1'b0;
        add_en     = 1'b0;
        shift      = 1'b0;
        last_iter  = 1'b0;
        done       = 2'b00;
        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    state_next = S_INIT;
                end
            end
            S_INIT: begin
                init       = 1'b1;
                state_next = S_ADD;
            end
            S_ADD: begin
                add_en     = dp_lsb;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                shift = 1'b1;
                if (counter == CNT_ONE) begin
                    last_iter  = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_ADD;
                end
            end
            S_DONE: begin
                done       = {owner_r, ~owner_r};
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand steering: the owner's operands while busy, zero when idle
    always_comb begin
        busy      = (state != S_IDLE);
        owner     = owner_r;
        dp_mcand  = '0;
        dp_mplier = '0;
        if (state != S_IDLE) begin
            dp_mcand  = owner_r ? a1 : a0;
            dp_mplier = owner_r ? b1 : b0;
        end
    end

endmodule

// File: tb/tb_mult_share_sequencer.sv
// tb/tb_mult_share_sequencer.sv - directed self-checking bench for mult_share_sequencer
module tb_mult_share_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    logic         dp_lsb;
    logic [W-1:0] dp_mcand, dp_mplier;
    logic         init, add_en, shift, last_iter, busy, owner;
    logic [1:0]   done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W:0] prod_reg  = '0;
    logic [W-1:0] mcand_reg = '0;

    mult_share_sequencer #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .dp_lsb(dp_lsb), .dp_mcand(dp_mcand), .dp_mplier(dp_mplier),
        .init(init), .add_en(add_en), .shift(shift), .last_iter(last_iter),
        .busy(busy), .owner(owner), .done(done)
    );

    always #5 clk = ~clk;

    // Shift-add datapath model: load on init, add multiplicand into upper half, shift right
    assign dp_lsb = prod_reg[0];
    always @(posedge clk) begin
        if (init) begin
            prod_reg  <= {{(W+1){1'b0}}, dp_mplier};
            mcand_reg <= dp_mcand;
        end else if (add_en) begin
            prod_reg[2*W:W] <= prod_reg[2*W:W] + {1'b0, mcand_reg};
        end else if (shift) begin
            prod_reg <= prod_reg >> 1;
        end
    end

    // Observes one operation until done (or a cycle budget expires), collecting what happened
    task automatic wait_done(input bit drop_after_init,
                             output int init_c, output int done_c, output int last_c,
                             output logic [1:0] done_v, output logic owner_v,
                             output logic [W-1:0] mplier_v, output logic [W-1:0] add_pat,
                             output int nadd, output int nshift, output int excl);
        int c = 0;
        init_c = -1; done_c = -1; last_c = -1; done_v = 2'b00; owner_v = 1'b0;
        mplier_v = '0; add_pat = '0; nadd = 0; nshift = 0; excl = 0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (init) begin
                init_c = c; owner_v = owner; mplier_v = dp_mplier;
                if (drop_after_init) req = 2'b00;
            end
            if (busy && !init && !shift && done == 2'b00) add_pat = {add_en, add_pat[W-1:1]};
            if (add_en) nadd++;
            if (shift) nshift++;
            if (last_iter) last_c = c;
            if (done == 2'b11 || (int'(init) + int'(add_en) + int'(shift)) > 1) excl++;
            if (done != 2'b00) begin
                done_v = done; done_c = c;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 2'b00; a0 = 4'd9; b0 = 4'd9; a1 = 4'd7; b1 = 4'd7;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d want 0", busy); end
        n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %0d want 0", done); end
        n_checks++; if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
        n_checks++; if ({init, add_en, shift, last_iter} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {init, add_en, shift, last_iter}); end
        n_checks++; if ({dp_mcand, dp_mplier} !== '0) begin n_fail++; $display("FAIL reset_operands: got %h want 0", {dp_mcand, dp_mplier}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int ic, dc, lc, na, ns, ex; logic [1:0] dv; logic ow; logic [W-1:0] mp, ap;
        a0 = 4'd5; b0 = 4'd3; req = 2'b01;
        wait_done(1'b0, ic, dc, lc, dv, ow, mp, ap, na, ns, ex);
        req = 2'b00;
        n_checks++; if (ic !== 1) begin n_fail++; $display("FAIL single_init_cycle: got %0d want 1", ic); end
        n_checks++; if (ow !== 1'b0) begin n_fail++; $display("FAIL single_owner: got %0d want 0", ow); end
        n_checks++; if (mp !== 4'd3) begin n_fail++; $display("FAIL single_mplier: got %0d want 3", mp); end
        n_checks++; if (ap !== 4'b0011) begin n_fail++; $display("FAIL single_add_pattern: got %b want 0011", ap); end
        n_checks++; if (ns !== W) begin n_fail++; $display("FAIL single_shifts: got %0d want %0d", ns, W); end
        n_checks++; if (lc !== 2*W+1) begin n_fail++; $display("FAIL single_last_iter: got %0d want %0d", lc, 2*W+1); end
        n_checks++; if (dc !== 2*W+2) begin n_fail++; $display("FAIL single_done_cycle: got %0d want %0d", dc, 2*W+2); end
        n_checks++; if (dv !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b want 01", dv); end
        n_checks++; if (prod_reg[2*W-1:0] !== 8'd15) begin n_fail++; $display("FAIL single_product: got %0d want 15", prod_reg[2*W-1:0]); end
        n_checks++; if (ex !== 0) begin n_fail++; $display("FAIL single_exclusive: got %0d want 0", ex); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: got %0d want 0", busy); end
    endtask

    task automatic test_simultaneous();
        int ic, dc, lc, na, ns, ex; logic [1:0] dv; logic ow; logic [W-1:0] mp, ap;
        pulse_reset();
        a0 = 4'd6; b0 = 4'd7; a1 = 4'd11; b1 = 4'd13; req = 2'b11;
        wait_done(1'b0, ic, dc, lc, dv, ow, mp, ap, na, ns, ex);
        req = 2'b10;
        n_checks++; if (ow !== 1'b0) begin n_fail++; $display("FAIL tie_first_owner: got %0d want 0", ow); end
        n_checks++; if (dv !== 2'b01) begin n_fail++; $display("FAIL tie_first_done: got %b want 01", dv); end
        n_checks++; if (mp !== 4'd7) begin n_fail++; $display("FAIL tie_first_mplier: got %0d want 7", mp); end
        n_checks++; if (prod_reg[2*W-1:0] !== 8'd42) begin n_fail++; $display("FAIL tie_first_product: got %0d want 42", prod_reg[2*W-1:0]); end
        wait_done(1'b0, ic, dc, lc, dv, ow, mp, ap, na, ns, ex);
        req = 2'b00;
        n_checks++; if (ow !== 1'b1) begin n_fail++; $display("FAIL tie_second_owner: got %0d want 1", ow); end
        n_checks++; if (dv !== 2'b10) begin n_fail++; $display("FAIL tie_second_done: got %b want 10", dv); end
        n_checks++; if (mp !== 4'd13) begin n_fail++; $display("FAIL tie_second_mplier: got %0d want 13", mp); end
        n_checks++; if (prod_reg[2*W-1:0] !== 8'd143) begin n_fail++; $display("FAIL tie_second_product: got %0d want 143", prod_reg[2*W-1:0]); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int ic, dc, lc, na, ns, ex; logic [1:0] dv; logic ow; logic [W-1:0] mp, ap;
        int ex_total = 0;
        pulse_reset();
        req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_done(1'b0, ic, dc, lc, dv, ow, mp, ap, na, ns, ex);
            ex_total += ex;
            n_checks++; if (ow !== 1'(i % 2)) begin n_fail++; $display("FAIL contention_owner[%0d]: got %0d want %0d", i, ow, i % 2); end
            n_checks++; if (dv !== (2'b01 << (i % 2))) begin n_fail++; $display("FAIL contention_done[%0d]: got %b want %b", i, dv, 2'b01 << (i % 2)); end
        end
        req = 2'b00;
        n_checks++; if (ex_total !== 0) begin n_fail++; $display("FAIL contention_exclusive: got %0d want 0", ex_total); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ic, dc, lc, na, ns, ex; logic [1:0] dv; logic ow; logic [W-1:0] mp, ap;
        int adds = 0; int cyc = 0; int stray = 0;
        a0 = 4'd3; b0 = 4'd15; req = 2'b01;
        while (adds < 3 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (busy && !init && !shift && done == 2'b00) adds++;
        end
        n_checks++; if (adds !== 3) begin n_fail++; $display("FAIL midreset_reach_add: got %0d want 3", adds); end
        reset = 1'b1; req = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %0d want 0", busy); end
        n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL midreset_done: got %b want 00", done); end
        n_checks++; if (owner !== 1'b0) begin n_fail++; $display("FAIL midreset_owner: got %0d want 0", owner); end
        for (int i = 0; i < 2*W+4; i++) begin
            @(negedge clk);
            if (done != 2'b00 || busy) stray++;
        end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL midreset_stray_activity: got %0d want 0", stray); end
        req = 2'b11;
        wait_done(1'b0, ic, dc, lc, dv, ow, mp, ap, na, ns, ex);
        req = 2'b00;
        n_checks++; if (ow !== 1'b0) begin n_fail++; $display("FAIL midreset_tie_owner: got %0d want 0", ow); end
        n_checks++; if (dv !== 2'b01) begin n_fail++; $display("FAIL midreset_tie_done: got %b want 01", dv); end
        @(negedge clk);
    endtask

    task automatic test_early_drop();
        int ic, dc, lc, na, ns, ex; logic [1:0] dv; logic ow; logic [W-1:0] mp, ap;
        int extra = 0;
        a1 = 4'd7; b1 = 4'd5; req = 2'b10;
        wait_done(1'b1, ic, dc, lc, dv, ow, mp, ap, na, ns, ex);
        n_checks++; if (dv !== 2'b10) begin n_fail++; $display("FAIL drop_done: got %b want 10", dv); end
        n_checks++; if (dc - ic !== 2*W+1) begin n_fail++; $display("FAIL drop_length: got %0d want %0d", dc - ic, 2*W+1); end
        n_checks++; if (ns !== W) begin n_fail++; $display("FAIL drop_shifts: got %0d want %0d", ns, W); end
        n_checks++; if (prod_reg[2*W-1:0] !== 8'd35) begin n_fail++; $display("FAIL drop_product: got %0d want 35", prod_reg[2*W-1:0]); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done != 2'b00 || busy) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL drop_returns_idle: got %0d want 0", extra); end
    endtask

    task automatic test_zero_mplier();
        int ic, dc, lc, na, ns, ex; logic [1:0] dv; logic ow; logic [W-1:0] mp, ap;
        a0 = 4'd9; b0 = 4'd0; req = 2'b01;
        wait_done(1'b0, ic, dc, lc, dv, ow, mp, ap, na, ns, ex);
        req = 2'b00;
        n_checks++; if (na !== 0) begin n_fail++; $display("FAIL zero_adds: got %0d want 0", na); end
        n_checks++; if (ns !== W) begin n_fail++; $display("FAIL zero_shifts: got %0d want %0d", ns, W); end
        n_checks++; if (dc !== 2*W+2) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want %0d", dc, 2*W+2); end
        n_checks++; if (dv !== 2'b01) begin n_fail++; $display("FAIL zero_done: got %b want 01", dv); end
        n_checks++; if (prod_reg[2*W-1:0] !== 8'd0) begin n_fail++; $display("FAIL zero_product: got %0d want 0", prod_reg[2*W-1:0]); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_contention();
        test_reset_mid();
        test_early_drop();
        test_zero_mplier();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
